multdiv_unit: RTL and testbench
===============================

Name: multdiv_unit

Overview:
- Multi-cycle 32-bit signed multiply/divide unit; sibling of the single-cycle ALU logic ops (AND/OR/ADD/shift).
- Its result joins the same execute-stage writeback mux as the ALU result; data_resultRDY tells the pipeline stall logic when to release.
- Radix-2 Booth multiply and non-restoring signed divide, one iteration per clock, with fixed latency.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported and verified.
- CNT_W, 5, iteration counter width (= log2 WIDTH).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; overrides all other inputs.
- ctrl_MULT  in  1  one-cycle start pulse for multiply.
- ctrl_DIV  in  1  one-cycle start pulse for divide.
- data_operandA  in  32  multiplicand / dividend (two's complement); sampled only on a start edge.
- data_operandB  in  32  multiplier / divisor (two's complement); sampled only on a start edge.
- data_result  out  32  product low word or quotient; held until the next start.
- data_exception  out  1  overflow or divide-by-zero flag; valid while data_resultRDY=1, then held.
- data_resultRDY  out  1  one-cycle pulse: result valid.
- busy  out  1  high from the cycle after a start until data_resultRDY.

Behaviour:
- Reset (synchronous): state=IDLE; counter=0; data_result=0, data_exception=0, data_resultRDY=0, busy=0. Reset in mid-operation aborts the operation and emits no RDY pulse.
- States:
  - IDLE: ctrl_MULT -> MUL; else ctrl_DIV -> DIV. If both are high in the same cycle, MULT wins. The start edge latches both operands and clears the counter.
  - MUL / DIV: one iteration per edge. After the 32nd iteration (counter==31), go to DONE and register the result and exception.
  - DONE: data_resultRDY=1 for exactly one cycle, then IDLE. A start in DONE is accepted, as in IDLE.
- Latency: start sampled at edge 0 -> data_resultRDY high in the cycle following edge 33. Back-to-back operations are possible with one cycle between RDY and the next start.
- Start while busy (MUL/DIV): the current operation is aborted and restarted with the new operands; no RDY pulse is emitted for the aborted operation.
- Multiply:
  - Full 64-bit signed product; data_result = product[31:0].
  - data_exception=1 iff product[63:31] is not all-equal (signed overflow).
- Divide:
  - Quotient truncated toward zero; remainder discarded.
  - Divisor==0: data_result=0, data_exception=1.
  - 0x80000000 / -1: data_result=0x80000000, data_exception=1.
  - Both cases still take the full 33-cycle latency unless the optional feature is enabled.
- Operands are internally registered, so data_operandA/B may change freely after the start edge.
- Outputs are registered (no combinational input-to-output path).

Optional Feature:
- Macro: MULTDIV_DIV0_FASTEXIT_EN.
- Defined: a divide with divisor==0 at the start edge goes directly to DONE, so data_resultRDY is high in the cycle after edge 1. Result and exception are the same as the non-fast path.
- Undefined: divide-by-zero uses the uniform 33-cycle latency.

Decomposition:
- Shared package multdiv_pkg holds:
  - the state enum (IDLE, MUL, DIV, DONE);
  - constants WIDTH=32, ITER=32, INT_MIN=32'h80000000.
- One natural sub-module, multdiv_step: combinational single-iteration datapath (Booth add/sub/shift, or divide add/sub/shift) selected by a mode bit. Instantiated once; the FSM and registers stay in multdiv_unit.

Test Plan:
- MULT A=7, B=-6 -> RDY exactly 33 cycles after start; result=0xFFFFFFD6 (-42); exception=0.
- MULT A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1.
- DIV A=-17, B=5 -> result=0xFFFFFFFD (-3), exception=0. Then DIV 0x80000000 / -1 -> result=0x80000000, exception=1.
- DIV A=123, B=0 -> result=0, exception=1, RDY at 33 cycles. With MULTDIV_DIV0_FASTEXIT_EN defined, RDY comes in the cycle after edge 1.
- MULT 3x4 started, then DIV 100/7 asserted 10 cycles later -> a single RDY pulse 33 cycles after the DIV start, result=14. A simultaneous ctrl_MULT+ctrl_DIV with A=5, B=2 -> result=10.
- Reset asserted at cycle 20 of a MULT -> next edge: all outputs 0, IDLE, no RDY pulse; a following MULT 2x3 returns 6.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multi-cycle signed multiply/divide unit.
// Optional build macro used by the unit: MULTDIV_DIV0_FASTEXIT_EN.
package multdiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int          WIDTH   = 32;
   localparam int          ITER    = 32;
   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   // Magnitude of a two's complement word; INT_MIN maps onto itself as unsigned 2^31.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/multdiv_step.sv
// One iteration of the shared datapath: radix-2 Booth step (mode=0) or
// unsigned non-restoring divide step on magnitudes (mode=1).
module multdiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             mode,
   input  logic [WIDTH:0]   acc,
   input  logic [WIDTH-1:0] q,
   input  logic             q_1,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH:0]   acc_next,
   output logic [WIDTH-1:0] q_next,
   output logic             q1_next
);

   logic [WIDTH:0] m_ext;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] sum;

   always_comb begin
      m_ext    = '0;
      shifted  = '0;
      sum      = '0;
      acc_next = acc;
      q_next   = q;
      q1_next  = 1'b0;
      if (!mode) begin
         m_ext = {m[WIDTH-1], m};
         case ({q[0], q_1})
            2'b01:   sum = acc + m_ext;
            2'b10:   sum = acc - m_ext;
            default: sum = acc;
         endcase
         acc_next = {sum[WIDTH], sum[WIDTH:1]};
         q_next   = {sum[0], q[WIDTH-1:1]};
         q1_next  = q[0];
      end else begin
         // Partial remainder stays within +/-2*divisor, so WIDTH+1 bits hold it.
         m_ext    = {1'b0, m};
         shifted  = {acc[WIDTH-1:0], q[WIDTH-1]};
         sum      = acc[WIDTH] ? (shifted + m_ext) : (shifted - m_ext);
         acc_next = sum;
         q_next   = {q[WIDTH-2:0], ~sum[WIDTH]};
      end
   end

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle 32-bit signed multiply/divide unit, fixed 33-cycle latency.
// MULTDIV_DIV0_FASTEXIT_EN: divide-by-zero skips the iterations and finishes at once.
module multdiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);
   import multdiv_pkg::*;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   acc;
   logic [WIDTH-1:0] q;
   logic             q_1;
   logic [WIDTH-1:0] m;
   logic             neg;
   logic             div_zero;
   logic             div_ovf;

   logic [WIDTH:0]     acc_n;
   logic [WIDTH-1:0]   q_n;
   logic               q1_n;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0]     prod_hi;
   logic               mul_ovf;
   logic [WIDTH-1:0]   quot;

   multdiv_step #(.WIDTH(WIDTH)) u_step (
      .mode     (state == DIV),
      .acc      (acc),
      .q        (q),
      .q_1      (q_1),
      .m        (m),
      .acc_next (acc_n),
      .q_next   (q_n),
      .q1_next  (q1_n)
   );

   assign prod    = {acc_n[WIDTH-1:0], q_n};
   assign prod_hi = prod[2*WIDTH-1:WIDTH-1];
   assign mul_ovf = !((prod_hi == '0) || (prod_hi == '1));
   assign quot    = neg ? (WIDTH'(0) - q_n) : q_n;

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         acc            <= '0;
         q              <= '0;
         q_1            <= 1'b0;
         m              <= '0;
         neg            <= 1'b0;
         div_zero       <= 1'b0;
         div_ovf        <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
         busy           <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         if (state == DONE) begin
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
            state          <= IDLE;
         end
         // A start is honoured in every state; in MUL/DIV it aborts the running op.
         if (ctrl_MULT || ctrl_DIV) begin
            cnt  <= '0;
            acc  <= '0;
            q_1  <= 1'b0;
            busy <= 1'b1;
            if (ctrl_MULT) begin
               state <= MUL;
               q     <= data_operandB;
               m     <= data_operandA;
            end else begin
               state    <= DIV;
               q        <= abs32(data_operandA);
               m        <= abs32(data_operandB);
               neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
               div_zero <= (data_operandB == '0);
               div_ovf  <= (data_operandA == INT_MIN) && (data_operandB == '1);
`ifdef MULTDIV_DIV0_FASTEXIT_EN
               if (data_operandB == '0) begin
                  state          <= DONE;
                  data_result    <= '0;
                  data_exception <= 1'b1;
               end
`endif
            end
         end else if ((state == MUL) || (state == DIV)) begin
            acc <= acc_n;
            q   <= q_n;
            q_1 <= q1_n;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(ITER - 1)) begin
               state <= DONE;
               if (state == MUL) begin
                  data_result    <= q_n;
                  data_exception <= mul_ovf;
               end else if (div_zero) begin
                  data_result    <= '0;
                  data_exception <= 1'b1;
               end else if (div_ovf) begin
                  data_result    <= INT_MIN;
                  data_exception <= 1'b1;
               end else begin
                  data_result    <= quot;
                  data_exception <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed and randomised checks of multdiv_unit: results, exceptions, latency,
// abort/restart, start priority and synchronous reset.
module tb_multdiv_unit;
   import multdiv_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [32:0] exp_q[$];
   int          cyc_q[$];

`ifdef MULTDIV_DIV0_FASTEXIT_EN
   localparam int DIV0_LAT = 1;
`else
   localparam int DIV0_LAT = 33;
`endif

   multdiv_unit dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   // clock / reset
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // reference model
   function automatic logic [32:0] model(input logic is_mul, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      logic [32:0] hi;
      if (is_mul) begin
         p  = 64'($signed(a)) * 64'($signed(b));
         hi = p[63:31];
         return {!((hi == '0) || (hi == '1)), p[31:0]};
      end
      if (b == 32'd0) return {1'b1, 32'd0};
      if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return {1'b1, 32'h8000_0000};
      return {1'b0, 32'($signed(a) / $signed(b))};
   endfunction

   // driver: start pulse, optional scoreboard push with the expected RDY cycle
   task automatic start_op(input logic mul, input logic dv, input logic [31:0] a,
                           input logic [31:0] b, input logic push, input int lat);
      @(negedge clock);
      ctrl_MULT     = mul;
      ctrl_DIV      = dv;
      data_operandA = a;
      data_operandB = b;
      @(negedge clock);
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
      if (push) begin
         exp_q.push_back(model(mul, a, b));
         cyc_q.push_back(cyc + lat);
      end
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0) && (n < budget)) begin
         @(negedge clock);
         #1;
         n++;
      end
      total++;
      assert (exp_q.size() == 0) else begin
         bad++;
         $error("FAIL timeout pending=%0d want=0", exp_q.size());
      end
      exp_q.delete();
      cyc_q.delete();
   endtask

   // scoreboard: every RDY pulse must match the head of the queue
   always @(negedge clock) begin
      logic [32:0] e;
      int          ec;
      if (data_resultRDY) begin
         total++;
         assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_rdy got=1 want=0 cyc=%0d", cyc);
         end
         if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            ec = cyc_q.pop_front();
            total++;
            assert (data_result === e[31:0]) else begin
               bad++;
               $error("FAIL result got=%h want=%h", data_result, e[31:0]);
            end
            total++;
            assert (data_exception === e[32]) else begin
               bad++;
               $error("FAIL exception got=%b want=%b", data_exception, e[32]);
            end
            total++;
            assert (cyc === ec) else begin
               bad++;
               $error("FAIL latency got_cyc=%0d want_cyc=%0d", cyc, ec);
            end
            total++;
            assert (busy === 1'b0) else begin
               bad++;
               $error("FAIL busy_at_rdy got=%b want=0", busy);
            end
         end
      end
   end

   initial begin
      reset         = 1'b1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      repeat (3) @(negedge clock);
      total++;
      assert ({data_result, data_exception, data_resultRDY, busy} === 35'd0) else begin
         bad++;
         $error("FAIL reset_outputs got=%h want=0", {data_result, data_exception, data_resultRDY, busy});
      end
      total++;
      assert (dut.state === IDLE) else begin
         bad++;
         $error("FAIL reset_state got=%0d want=%0d", dut.state, IDLE);
      end
      reset = 1'b0;

      // multiply: small signed, then overflow
      start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 1'b1, 33);
      total++;
      assert (busy === 1'b1) else begin
         bad++;
         $error("FAIL busy_after_start got=%b want=1", busy);
      end
      wait_done(60);
      start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1, 33);
      wait_done(60);

      // divide: truncation toward zero, INT_MIN/-1, divide by zero
      start_op(1'b0, 1'b1, 32'hFFFF_FFEF, 32'd5, 1'b1, 33);
      wait_done(60);
      start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33);
      wait_done(60);
      start_op(1'b0, 1'b1, 32'd123, 32'd0, 1'b1, DIV0_LAT);
      wait_done(60);

      // abort: MULT restarted by a DIV 10 cycles later gives a single RDY
      start_op(1'b1, 1'b0, 32'd3, 32'd4, 1'b0, 33);
      repeat (8) @(negedge clock);
      start_op(1'b0, 1'b1, 32'd100, 32'd7, 1'b1, 33);
      wait_done(60);

      // both starts at once: multiply wins
      start_op(1'b1, 1'b1, 32'd5, 32'd2, 1'b1, 33);
      wait_done(60);

      // reset in mid-operation: no RDY, outputs cleared, next op works
      start_op(1'b1, 1'b0, 32'd9, 32'd9, 1'b0, 33);
      repeat (18) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      total++;
      assert ({data_result, data_exception, data_resultRDY, busy} === 35'd0) else begin
         bad++;
         $error("FAIL midop_reset_outputs got=%h want=0", {data_result, data_exception, data_resultRDY, busy});
      end
      total++;
      assert (dut.state === IDLE) else begin
         bad++;
         $error("FAIL midop_reset_state got=%0d want=%0d", dut.state, IDLE);
      end
      repeat (20) @(negedge clock);
      start_op(1'b1, 1'b0, 32'd2, 32'd3, 1'b1, 33);
      wait_done(60);

      // randomised operations against the reference model
      for (int i = 0; i < 12; i++) begin
         logic        mul;
         logic [31:0] a;
         logic [31:0] b;
         mul = 1'($urandom_range(0, 1));
         a   = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed(16'($urandom)));
         b   = ($urandom_range(0, 3) == 0) ? 32'($signed(8'($urandom))) : $urandom;
         if ($urandom_range(0, 9) == 0) b = 32'd0;
         start_op(mul, !mul, a, b, 1'b1, (!mul && (b == 32'd0)) ? DIV0_LAT : 33);
         wait_done(60);
      end

      repeat (5) @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
